// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - handshake/status bundle between the UART receive FIFO and its neighbours
interface uart_rx_fifo_if #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4
);
    logic                 wr_i;
    logic [WORD_BITS-1:0] wr_data_i;
    logic                 rd_i;
    logic                 clear_i;
    logic [WORD_BITS-1:0] rd_data_o;
    logic                 empty_o;
    logic                 full_o;
    logic [ADDR_BITS:0]   count_o;
    logic                 overflow_o;
    logic                 underflow_o;

    modport master (
        output wr_i, wr_data_i, rd_i, clear_i,
        input  rd_data_o, empty_o, full_o, count_o, overflow_o, underflow_o
    );

    modport slave (
        input  wr_i, wr_data_i, rd_i, clear_i,
        output rd_data_o, empty_o, full_o, count_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with sticky overflow/underflow flags
module uart_rx_fifo #(
    parameter int WORD_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input logic           clk_i,
    input logic           reset_i,
    uart_rx_fifo_if.slave bus
);
    localparam int                 DEPTH     = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] CNT_FULL  = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0] CNT_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] PTR_ONE = ADDR_BITS'(1);

    logic [WORD_BITS-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic                 overflow;
    logic                 underflow;

    logic empty;
    logic full;
    logic wr_ok;
    logic rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A full FIFO still takes a write when a pop frees the same slot this cycle
    assign wr_ok = bus.wr_i && (!full || bus.rd_i);
    assign rd_ok = bus.rd_i && !empty;

    assign bus.rd_data_o   = mem[rd_ptr];
    assign bus.empty_o     = empty;
    assign bus.full_o      = full;
    assign bus.count_o     = count;
    assign bus.overflow_o  = overflow;
    assign bus.underflow_o = underflow;

    // Storage write; not reset, and suppressed by clear or an asserted reset
    always_ff @(posedge clk_i) begin
        if (wr_ok && !bus.clear_i && !reset_i) begin
            mem[wr_ptr] <= bus.wr_data_i;
        end
    end

    // Pointers, occupancy and sticky flags; clear wins over both strobes
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (bus.clear_i) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + CNT_ONE;
            end else if (rd_ok && !wr_ok) begin
                count <= count - CNT_ONE;
            end
            if (bus.wr_i && full && !bus.rd_i) begin
                overflow <= 1'b1;
            end
            if (bus.rd_i && empty) begin
                underflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic reset_i = 1'b1;

    uart_rx_fifo_if #(.WORD_BITS(8), .ADDR_BITS(4)) bus ();

    uart_rx_fifo #(.WORD_BITS(8), .ADDR_BITS(4)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop presents a word that must match the oldest expected one
    always @(negedge clk) begin
        if (!reset_i && !bus.clear_i && bus.rd_i && !bus.empty_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop_data: got %0h expected nothing stored", bus.rd_data_o);
            end else begin
                check("pop_data", 32'(bus.rd_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; the model is updated after the edge
    task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
        int  sz;
        logic wacc;
        sz   = exp_q.size();
        wacc = w && (sz < 16 || r);
        bus.wr_i      = w;
        bus.wr_data_i = d;
        bus.rd_i      = r;
        bus.clear_i   = c;
        @(posedge clk);
        #1;
        if (c) exp_q.delete();
        else if (wacc) exp_q.push_back(d);
        bus.wr_i    = 1'b0;
        bus.rd_i    = 1'b0;
        bus.clear_i = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_empty"}, 32'(bus.empty_o), 32'd1);
        check({tag, "_full"}, 32'(bus.full_o), 32'd0);
        check({tag, "_count"}, 32'(bus.count_o), 32'd0);
        check({tag, "_ovf"}, 32'(bus.overflow_o), 32'd0);
        check({tag, "_udf"}, 32'(bus.underflow_o), 32'd0);
    endtask

    initial begin
        bus.wr_i = 1'b0; bus.wr_data_i = 8'h00; bus.rd_i = 1'b0; bus.clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        reset_i = 1'b0;

        // Single word
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        check("single_empty", 32'(bus.empty_o), 32'd0);
        check("single_count", 32'(bus.count_o), 32'd1);
        check("single_data", 32'(bus.rd_data_o), 32'hA5);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("single_pop_empty", 32'(bus.empty_o), 32'd1);
        check("single_pop_count", 32'(bus.count_o), 32'd0);

        // Fill and wrap
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        check("fill_full", 32'(bus.full_o), 32'd1);
        check("fill_count", 32'(bus.count_o), 32'd16);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("half_count", 32'(bus.count_o), 32'd8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("wrap_empty", 32'(bus.empty_o), 32'd1);
        check("wrap_udf", 32'(bus.underflow_o), 32'd0);

        // Overflow
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b0);
        check("ovf_flag", 32'(bus.overflow_o), 32'd1);
        check("ovf_count", 32'(bus.count_o), 32'd16);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("ovf_drained", 32'(bus.count_o), 32'd0);
        check("ovf_sticky", 32'(bus.overflow_o), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_idle("ovf_clear");

        // Simultaneous read/write while full, then while empty
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        check("full_rw_count", 32'(bus.count_o), 32'd16);
        check("full_rw_ovf", 32'(bus.overflow_o), 32'd0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        check("empty_rw_count", 32'(bus.count_o), 32'd1);
        check("empty_rw_udf", 32'(bus.underflow_o), 32'd1);
        check("empty_rw_data", 32'(bus.rd_data_o), 32'h33);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check_idle("rw_clear");

        // Asynchronous reset between edges
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        check("pre_reset_count", 32'(bus.count_o), 32'd5);
        #2;
        reset_i = 1'b1;
        #1;
        exp_q.delete();
        check_idle("async_reset");
        @(posedge clk);
        #3;
        reset_i = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        check("post_reset_data", 32'(bus.rd_data_o), 32'h42);
        check("post_reset_count", 32'(bus.count_o), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Clear beats simultaneous write and read
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        check_idle("clear_prio");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
